// File: rtl/ks_datapath_gen2.sv
// K&S second-generation data path: PC, IR, register bank,
// four-operation ALU and registered flags.
module ks_datapath_gen2 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 4,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_enable,
  input  logic              branch,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic [1:0]        operation,
  input  logic              write_reg_enable,
  input  logic              flags_reg_enable,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_AW-1:0] c_addr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              zero_op,
  output logic              neg_op,
  output logic              unsigned_overflow,
  output logic              signed_overflow
);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] reg_q [NREGS];
  logic [DATA_W-1:0] reg_d [NREGS];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [3:0]        flags_q, flags_d;

  logic [DATA_W-1:0] bus_a, bus_b, bus_c;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W:0]   add_x, sub_x;
  logic              uovf, sovf;

  assign bus_a = reg_q[a_addr];
  assign bus_b = reg_q[b_addr];

  always_comb begin
    add_x = {1'b0, bus_a} + {1'b0, bus_b};
    sub_x = {1'b0, bus_a} + {1'b0, ~bus_b}
          + {{DATA_W{1'b0}}, 1'b1};
    alu_out = '0;
    uovf = 1'b0;
    sovf = 1'b0;
    unique case (operation)
      2'b00: begin
        alu_out = add_x[MSB:0];
        uovf = add_x[DATA_W];
        // carry into MSB recovered from the sum bit
        sovf = (bus_a[MSB] ^ bus_b[MSB] ^ alu_out[MSB])
             ^ add_x[DATA_W];
      end
      2'b01: alu_out = bus_a & bus_b;
      2'b10: alu_out = bus_a | bus_b;
      2'b11: begin
        alu_out = sub_x[MSB:0];
        uovf = ~sub_x[DATA_W];
        sovf = (bus_a[MSB] != bus_b[MSB])
            && (alu_out[MSB] != bus_a[MSB]);
      end
      default: alu_out = '0;
    endcase
  end

  assign bus_c = c_sel ? data_in : alu_out;

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    flags_d = flags_q;
    for (int i = 0; i < NREGS; i++) reg_d[i] = reg_q[i];
    if (pc_enable)
      pc_d = branch ? mem_addr : pc_q + 1'b1;
    if (ir_enable) ir_d = data_in;
    if (flags_reg_enable)
      flags_d = {alu_out == '0, alu_out[MSB], uovf, sovf};
    if (write_reg_enable) reg_d[c_addr] = bus_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      ir_q <= '0;
      flags_q <= '0;
      for (int i = 0; i < NREGS; i++) reg_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      flags_q <= flags_d;
      for (int i = 0; i < NREGS; i++) reg_q[i] <= reg_d[i];
    end
  end

  assign instruction = ir_q;
  assign pc = pc_q;
  assign ram_addr = addr_sel ? mem_addr : pc_q;
  assign data_out = bus_a;
  assign zero_op = flags_q[3];
  assign neg_op = flags_q[2];
  assign unsigned_overflow = flags_q[1];
  assign signed_overflow = flags_q[0];
endmodule

// File: tb/tb_ks_datapath_gen2.sv
// Bench for ks_datapath_gen2: random stimulus against an
// arithmetic model, plus directed checks on a narrow instance.
module tb_ks_datapath_gen2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pc_enable, branch, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic wr, fl;
  logic [1:0] a_addr, b_addr, c_addr;
  logic [4:0] mem_addr;
  logic [15:0] data_in;
  logic [15:0] instruction, data_out;
  logic [4:0] pc, ram_addr;
  logic zf, nf, uf, sf;

  ks_datapath_gen2 dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable),
    .branch(branch), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(wr),
    .flags_reg_enable(fl), .a_addr(a_addr),
    .b_addr(b_addr), .c_addr(c_addr),
    .mem_addr(mem_addr), .data_in(data_in),
    .instruction(instruction), .pc(pc),
    .ram_addr(ram_addr), .data_out(data_out),
    .zero_op(zf), .neg_op(nf),
    .unsigned_overflow(uf), .signed_overflow(sf)
  );

  logic p_rst, p_wr, p_fl, p_csel;
  logic [1:0] p_op;
  logic [2:0] p_a, p_b, p_c;
  logic [7:0] p_din, p_ir, p_dout;
  logic [5:0] p_pc, p_ram;
  logic p_z, p_n, p_u, p_s;

  ks_datapath_gen2 #(.DATA_W(8), .ADDR_W(6), .NREGS(8)) d8 (
    .clk(clk), .rst(p_rst), .pc_enable(1'b0),
    .branch(1'b0), .ir_enable(1'b0), .addr_sel(1'b0),
    .c_sel(p_csel), .operation(p_op),
    .write_reg_enable(p_wr), .flags_reg_enable(p_fl),
    .a_addr(p_a), .b_addr(p_b), .c_addr(p_c),
    .mem_addr(6'd0), .data_in(p_din),
    .instruction(p_ir), .pc(p_pc), .ram_addr(p_ram),
    .data_out(p_dout), .zero_op(p_z), .neg_op(p_n),
    .unsigned_overflow(p_u), .signed_overflow(p_s)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] m_reg [4];
  logic [4:0] m_pc;
  logic [15:0] m_ir;
  logic [3:0] m_fl;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] a, b, r;
    logic [16:0] w;
    logic u;
    int sv;
    a = m_reg[a_addr];
    b = m_reg[b_addr];
    r = '0; u = 1'b0; sv = 0;
    case (operation)
      2'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0]; u = w[16];
        sv = int'($signed(a)) + int'($signed(b));
      end
      2'd1: r = a & b;
      2'd2: r = a | b;
      default: begin
        r = a - b; u = a < b;
        sv = int'($signed(a)) - int'($signed(b));
      end
    endcase
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_pc = '0; m_ir = '0; m_fl = '0;
    end else begin
      if (wr) m_reg[c_addr] = c_sel ? data_in : r;
      if (fl)
        m_fl = {r == 0, r[15], u, sv > 32767 || sv < -32768};
      if (pc_enable) m_pc = branch ? mem_addr : m_pc + 5'd1;
      if (ir_enable) m_ir = data_in;
    end
  endtask

  task automatic tick();
    #1;
    chk("pc", pc, m_pc);
    chk("ir", instruction, m_ir);
    chk("flags", {zf, nf, uf, sf}, m_fl);
    chk("data_out", data_out, m_reg[a_addr]);
    chk("ram_addr", ram_addr, addr_sel ? mem_addr : m_pc);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; pc_enable = 0; branch = 0; ir_enable = 0;
    addr_sel = 0; c_sel = 0; wr = 0; fl = 0;
  endtask

  task automatic ld(int r, logic [15:0] v);
    idle(); c_sel = 1; wr = 1; addr_sel = 1;
    c_addr = 2'(r); data_in = v; tick();
  endtask

  task automatic alu(int op, int a, int b, int c, logic f);
    idle(); operation = 2'(op); a_addr = 2'(a);
    b_addr = 2'(b); c_addr = 2'(c); wr = 1; fl = f;
    tick();
  endtask

  task automatic rd(int r, logic [15:0] v, string nm);
    idle(); wr = 0; a_addr = 2'(r); #1;
    chk(nm, data_out, v); tick();
  endtask

  task automatic flg(logic [3:0] v, string nm);
    idle(); #1; chk(nm, {zf, nf, uf, sf}, v); tick();
  endtask

  task automatic pcchk(logic [4:0] v, string nm);
    idle(); #1; chk(nm, pc, v); tick();
  endtask

  task automatic step8();
    @(negedge clk);
  endtask

  initial begin
    idle(); rst = 1;
    operation = 0; a_addr = 0; b_addr = 0; c_addr = 0;
    mem_addr = 0; data_in = 0;
    p_rst = 1; p_wr = 0; p_fl = 0; p_csel = 0; p_op = 0;
    p_a = 0; p_b = 0; p_c = 0; p_din = 0;
    foreach (m_reg[i]) m_reg[i] = '0;
    m_pc = 0; m_ir = 0; m_fl = 0;
    @(negedge clk);
    tick();
    p_rst = 0;

    ld(0, 16'h7FFF); ld(1, 16'h0001);
    alu(0, 0, 1, 2, 1);
    rd(2, 16'h8000, "add_ovf_r");
    flg(4'b0101, "add_ovf_flags");
    ld(0, 16'hFFFF);
    alu(0, 0, 1, 3, 1);
    rd(3, 16'h0000, "add_wrap_r");
    flg(4'b1010, "add_wrap_flags");
    ld(0, 16'h0003); ld(1, 16'h0005);
    alu(3, 0, 1, 2, 1);
    rd(2, 16'hFFFE, "sub_borrow_r");
    flg(4'b0110, "sub_borrow_flags");
    ld(0, 16'h8000); ld(1, 16'h0001);
    alu(3, 0, 1, 2, 1);
    rd(2, 16'h7FFF, "sub_sovf_r");
    flg(4'b0001, "sub_sovf_flags");
    ld(0, 16'hF0F0); ld(1, 16'h0F0F);
    alu(1, 0, 1, 2, 1);
    flg(4'b1000, "and_flags");
    alu(2, 0, 1, 3, 0);
    flg(4'b1000, "or_flags_held");
    rd(3, 16'hFFFF, "or_r");

    idle(); pc_enable = 1; branch = 1; mem_addr = 5'd30;
    tick();
    pcchk(5'd30, "pc_30");
    idle(); pc_enable = 1; tick();
    pcchk(5'd31, "pc_31");
    idle(); pc_enable = 1; tick();
    pcchk(5'd0, "pc_wrap");
    idle(); pc_enable = 1; branch = 1; mem_addr = 5'h12;
    tick();
    pcchk(5'h12, "pc_branch");
    idle(); branch = 1; mem_addr = 5'h05; tick();
    pcchk(5'h12, "pc_branch_noen");
    idle(); ir_enable = 1; data_in = 16'hABCD; tick();
    idle(); #1; chk("ir_load", instruction, 16'hABCD);

    for (int i = 0; i < 4; i++) ld(i, 16'h1111 * (i + 1));
    alu(3, 0, 1, 0, 1);
    idle(); rst = 1; wr = 1; c_sel = 1; c_addr = 1;
    data_in = 16'h1234; tick();
    idle(); #1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", instruction, 0);
    chk("rst_flags", {zf, nf, uf, sf}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    for (int i = 0; i < 4; i++) rd(i, 16'h0, "rst_reg");

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(63) == 0);
      pc_enable = 1'($urandom); branch = 1'($urandom);
      ir_enable = 1'($urandom); addr_sel = 1'($urandom);
      c_sel = 1'($urandom); operation = 2'($urandom);
      wr = 1'($urandom); fl = 1'($urandom);
      a_addr = 2'($urandom); b_addr = 2'($urandom);
      c_addr = 2'($urandom); mem_addr = 5'($urandom);
      case ($urandom_range(3))
        0: data_in = 16'h8000 ^ 16'($urandom_range(1));
        1: data_in = 16'hFFFF - 16'($urandom_range(1));
        default: data_in = 16'($urandom);
      endcase
      tick();
    end

    p_csel = 1; p_wr = 1;
    for (int i = 0; i < 8; i++) begin
      p_c = 3'(i); p_din = 8'(8'h21 * (i + 1)); step8();
    end
    p_wr = 0;
    for (int i = 0; i < 8; i++) begin
      p_a = 3'(i); #1;
      chk("p8_reg", p_dout, 8'(8'h21 * (i + 1)));
      step8();
    end
    p_wr = 1; p_c = 0; p_din = 8'h7F; step8();
    p_c = 1; p_din = 8'h01; step8();
    p_csel = 0; p_op = 0; p_a = 0; p_b = 1; p_c = 2;
    p_fl = 1; step8();
    p_wr = 0; p_fl = 0; p_a = 2; #1;
    chk("p8_add_r", p_dout, 8'h80);
    chk("p8_add_flags", {p_z, p_n, p_u, p_s}, 4'b0101);
    step8();
    p_csel = 1; p_wr = 1; p_c = 5; p_a = 5; p_din = 8'h5A;
    #1; chk("p8_no_bypass", p_dout, 8'hC6);
    step8();
    p_wr = 0; #1; chk("p8_written", p_dout, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ks_datapath_gen2.md
# ks_datapath_gen2

Parametrised second-generation K&S data path: program counter, instruction register, general-purpose register bank, four-operation ALU (add, and, or, sub) and registered flags. Data width, memory address width and register count are parameters. The ALU implements subtraction with full borrow and signed-overflow semantics. All state uses a synchronous active-high reset. The block sits between the K&S control unit and the unified program/data RAM. Instruction-field decoding lives in a separate decoder block, which drives the register and memory addresses into this one.

## Interface
- DATA_W, 16, width of data words, instruction register and registers
- ADDR_W, 5, RAM address width; width of PC and branch/memory address
- NREGS, 4, number of general-purpose registers (power of two, ≥2); REG_AW = $clog2(NREGS)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous and active-high
- pc_enable  in  1  PC update strobe
- branch  in  1  with pc_enable: PC ← mem_addr, else PC ← PC+1
- ir_enable  in  1  IR ← data_in
- addr_sel  in  1  0: ram_addr = PC; 1: ram_addr = mem_addr
- c_sel  in  1  write-back source; 0: ALU result; 1: data_in
- operation  in  2  00 add, 01 and, 10 or, 11 sub
- write_reg_enable  in  1  reg[c_addr] ← bus_c
- flags_reg_enable  in  1  capture ALU flags
- a_addr, b_addr, c_addr  in  REG_AW  register selects from decoder
- mem_addr  in  ADDR_W  memory/branch target from decoder
- data_in  in  DATA_W  RAM read data
- instruction  out  DATA_W  IR contents
- pc  out  ADDR_W  current program counter
- ram_addr  out  ADDR_W  RAM address (combinational)
- data_out  out  DATA_W  RAM write data = bus_a (combinational)
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags

## Operation
- bus_a = reg[a_addr], bus_b = reg[b_addr]. Reads are combinational.
- bus_c = c_sel ? data_in : alu_out.
- ALU results, all computed at DATA_W bits, with MSB = bit DATA_W-1:
  - add: {cout, r} = a + b; unsigned_ovf = cout; signed_ovf = carry into MSB XOR cout.
  - sub: r = a + ~b + 1; unsigned_ovf = borrow = (a < b unsigned); signed_ovf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]).
  - and / or: bitwise; both overflow flags 0.
  - zero = (r == 0); neg = r[MSB].
- Flags register loads {zero, neg, unsigned_ovf, signed_ovf} when flags_reg_enable=1 and holds otherwise.
- Register file: NREGS×DATA_W, all registers writable, no hard-wired zero.
  - Write occurs on posedge when write_reg_enable=1.
  - A same-cycle read of c_addr returns the old value; there is no bypass.
- PC:
  - Increments modulo 2^ADDR_W, so all-ones wraps to 0.
  - When branch=1 and pc_enable=1, PC loads mem_addr.
  - branch is ignored when pc_enable=0.
- IR loads data_in when ir_enable=1 and holds otherwise.
- All enables are independent. Any combination may be asserted in the same cycle, and each target updates per its own rule.

## Timing
- Reset (rst=1 at posedge) takes priority over every enable. After reset: PC=0, IR=0, all registers=0, all four flags=0.
- A reset asserted mid-instruction discards any write in that cycle.
- Outputs after reset:
  - ram_addr = 0 when addr_sel=0.
  - data_out = 0.
- Latency:
  - Register write, flag capture, PC update and IR load are visible one cycle after the enabling edge.
  - ram_addr, data_out and alu_out are combinational from current state and inputs (zero cycles).
- ALU op, write-back and flag capture complete in one cycle when write_reg_enable and flags_reg_enable are asserted together. The flags then correspond to the result being written.
- Load: addr_sel=1, c_sel=1, write_reg_enable=1 in the cycle RAM data is valid. The RAM read latency is owned by the control unit.

## Test plan
- Reset: load non-zero values into all regs, PC, IR and flags, then assert rst for 1 cycle. Every register, PC, instruction and each flag reads 0 on the next cycle.
- Add overflow (DATA_W=16): r0=0x7FFF, r1=0x0001, add into r2 with flags enabled. Result: r2=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- Add wrap and sub borrow:
  - 0xFFFF + 0x0001 gives r=0x0000, zero=1, unsigned_overflow=1, signed_overflow=0.
  - 0x0003 − 0x0005 gives 0xFFFE, neg=1, unsigned_overflow=1.
  - 0x8000 − 0x0001 gives 0x7FFF, signed_overflow=1.
- And/or with flags held: 0xF0F0 & 0x0F0F gives 0, zero=1. A following or with flags_reg_enable=0 leaves zero=1.
- PC wrap and branch (ADDR_W=5):
  - Step pc_enable from 30 to 31 to 0.
  - branch=1 with mem_addr=0x12 and pc_enable=1 gives pc=0x12.
  - branch=1 with pc_enable=0 leaves pc unchanged.
- Parametrisation: run DATA_W=8, NREGS=8, ADDR_W=6.
  - Write every register with a distinct value and read each back.
  - 0x7F + 0x01 sets signed_overflow=1.
  - Same-cycle read of the written register returns the old value.
